// File: rtl/activation_pipe_mc.sv
// activation_pipe_mc: CH-lane SONF activation pipeline (sigmoid/tanh/relu/identity).
// Four register stages with valid/ready on both sides and a saturation-event counter.
module activation_pipe_mc #(
   parameter int CH      = 4,
   parameter int WIDTH_X = 17,
   parameter int FRAC_X  = 12,
   parameter int WIDTH_Y = 16,
   parameter int FRAC_Y  = 14,
   parameter int CNT_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [1:0]              in_mode,
   input  logic                    in_last,
   input  logic [CH*WIDTH_X-1:0]   x,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic [CH*WIDTH_Y-1:0]   y,
   input  logic                    sat_clr,
   output logic [CNT_W-1:0]        sat_cnt
);

   localparam logic [1:0] M_SIG  = 2'b00;
   localparam logic [1:0] M_TANH = 2'b01;
   localparam logic [1:0] M_RELU = 2'b10;
   localparam logic [1:0] M_ID   = 2'b11;

   localparam int UW = WIDTH_X + 2;
   localparam int TW = FRAC_X + 1;
   localparam int PW = 2 * TW;
   localparam int QW = 2 * FRAC_X + 4;
   localparam int SH = 2 * FRAC_X + 1 - FRAC_Y;
   localparam int DS = FRAC_Y - FRAC_X;
   localparam int LS = (DS > 0) ? DS : 0;
   localparam int RS = (DS < 0) ? -DS : 0;
   localparam int WA = WIDTH_X + LS + 2;
   localparam int WW = (WA > WIDTH_Y + 1) ? WA : WIDTH_Y + 1;

   localparam logic [UW-1:0] FOUR = UW'(4 << FRAC_X);
   localparam logic signed [QW-1:0] ONE = QW'(1 << (2 * FRAC_X + 1));
   localparam logic signed [QW-1:0] RND = QW'(1 << (SH - 1));
   localparam logic signed [WW-1:0] RHALF = WW'((1 << RS) >> 1);

   logic en;

   assign in_ready = ~(out_valid & ~out_ready);
   assign en       = in_ready;

   // Stage 1: input capture
   logic                      s1_v;
   logic                      s1_last;
   logic [1:0]                s1_mode;
   logic signed [WIDTH_X-1:0] s1_x [CH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v    <= 1'b0;
         s1_last <= 1'b0;
         s1_mode <= '0;
         for (int i = 0; i < CH; i++)
            s1_x[i] <= '0;
      end else if (en) begin
         s1_v    <= in_valid;
         s1_last <= in_last;
         s1_mode <= in_mode;
         for (int i = 0; i < CH; i++)
            s1_x[i] <= x[i*WIDTH_X +: WIDTH_X];
      end
   end

   logic signed [UW-1:0] u  [CH];
   logic [UW-1:0]        a  [CH];
   logic [UW-1:0]        ac [CH];
   logic [TW-1:0]        t  [CH];
   logic [CH-1:0]        sgn;

   // t is floored when |u| is not a multiple of 4 lsb
   always_comb begin
      sgn = '0;
      for (int i = 0; i < CH; i++) begin
         u[i] = (s1_mode == M_TANH) ? (UW'(s1_x[i]) <<< 1)
                                    : UW'(s1_x[i]);
         sgn[i] = u[i][UW-1];
         a[i]  = sgn[i] ? -u[i] : u[i];
         ac[i] = (a[i] > FOUR) ? FOUR : a[i];
         t[i]  = TW'((FOUR - ac[i]) >> 2);
      end
   end

   // Stage 2: sign and t
   logic                      s2_v;
   logic                      s2_last;
   logic [1:0]                s2_mode;
   logic [CH-1:0]             s2_s;
   logic [TW-1:0]             s2_t [CH];
   logic signed [WIDTH_X-1:0] s2_x [CH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_v    <= 1'b0;
         s2_last <= 1'b0;
         s2_mode <= '0;
         s2_s    <= '0;
         for (int i = 0; i < CH; i++) begin
            s2_t[i] <= '0;
            s2_x[i] <= '0;
         end
      end else if (en) begin
         s2_v    <= s1_v;
         s2_last <= s1_last;
         s2_mode <= s1_mode;
         s2_s    <= sgn;
         for (int i = 0; i < CH; i++) begin
            s2_t[i] <= t[i];
            s2_x[i] <= s1_x[i];
         end
      end
   end

   logic [PW-1:0] p [CH];

   always_comb begin
      for (int i = 0; i < CH; i++)
         p[i] = PW'(s2_t[i]) * PW'(s2_t[i]);
   end

   // Stage 3: p = t*t
   logic                      s3_v;
   logic                      s3_last;
   logic [1:0]                s3_mode;
   logic [CH-1:0]             s3_s;
   logic [PW-1:0]             s3_p [CH];
   logic signed [WIDTH_X-1:0] s3_x [CH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s3_v    <= 1'b0;
         s3_last <= 1'b0;
         s3_mode <= '0;
         s3_s    <= '0;
         for (int i = 0; i < CH; i++) begin
            s3_p[i] <= '0;
            s3_x[i] <= '0;
         end
      end else if (en) begin
         s3_v    <= s2_v;
         s3_last <= s2_last;
         s3_mode <= s2_mode;
         s3_s    <= s2_s;
         for (int i = 0; i < CH; i++) begin
            s3_p[i] <= p[i];
            s3_x[i] <= s2_x[i];
         end
      end
   end

   // q is kept in Q.(2*FRAC_X+1) so p/2 stays exact
   logic signed [QW-1:0]      q  [CH];
   logic signed [QW-1:0]      v  [CH];
   logic [WIDTH_Y-1:0]        vr [CH];
   logic signed [WW-1:0]      r  [CH];
   logic signed [WW-1:0]      sc [CH];
   logic [WIDTH_Y-1:0]        yn [CH];
   logic [CH-1:0]             ok;
   logic [CH-1:0]             lsat;
   logic [CH*WIDTH_Y-1:0]     ycat;

   always_comb begin
      ok   = '0;
      lsat = '0;
      ycat = '0;
      for (int i = 0; i < CH; i++) begin
         q[i] = ONE - QW'(s3_p[i]);
         if (s3_s[i])
            q[i] = ONE - q[i];
         v[i]  = (s3_mode == M_TANH) ? (q[i] <<< 1) - ONE : q[i];
         vr[i] = WIDTH_Y'((v[i] + RND) >>> SH);
         r[i]  = (s3_mode == M_RELU && s3_x[i][WIDTH_X-1]) ? '0
                                                           : WW'(s3_x[i]);
         sc[i] = ((r[i] <<< LS) + RHALF) >>> RS;
         ok[i] = (&sc[i][WW-1:WIDTH_Y-1]) | ~(|sc[i][WW-1:WIDTH_Y-1]);
         yn[i] = vr[i];
         unique case (s3_mode)
            M_SIG, M_TANH: yn[i] = vr[i];
            M_RELU, M_ID: begin
               lsat[i] = ~ok[i];
               if (ok[i])
                  yn[i] = sc[i][WIDTH_Y-1:0];
               else if (sc[i][WW-1])
                  yn[i] = {1'b1, {(WIDTH_Y-1){1'b0}}};
               else
                  yn[i] = {1'b0, {(WIDTH_Y-1){1'b1}}};
            end
         endcase
         ycat[i*WIDTH_Y +: WIDTH_Y] = yn[i];
      end
   end

   // Stage 4: output register
   logic out_sat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_sat   <= 1'b0;
         y         <= '0;
      end else if (en) begin
         out_valid <= s3_v;
         out_last  <= s3_v & s3_last;
         out_sat   <= s3_v & (|lsat);
         y         <= s3_v ? ycat : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sat_cnt <= '0;
      else if (sat_clr)
         sat_cnt <= '0;
      else if (out_valid & out_ready & out_sat & ~&sat_cnt)
         sat_cnt <= sat_cnt + CNT_W'(1);
   end

endmodule
